// File: rtl/window_gen_5x5_pkg.sv
// Shared constants for the 5x5 sliding-window generator.
// Pixel width, kernel size and default image geometry.
package window_gen_5x5_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int KERNEL     = 5;
  localparam int IMG_W_DEF  = 28;
  localparam int IMG_H_DEF  = 28;
endpackage

// File: rtl/window_gen_5x5_line_delay.sv
// Valid-enabled circular delay line: dout is the sample written DEPTH accepted beats ago.
// Combinational read, no backpressure; contents are never cleared.
module line_delay #(
  parameter int DATA_WIDTH = window_gen_5x5_pkg::DATA_WIDTH,
  parameter int DEPTH      = window_gen_5x5_pkg::IMG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         ptr;

  // Read-before-write at the same slot gives exactly DEPTH beats of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end
endmodule

// File: rtl/window_gen_5x5.sv
// Raster-stream to 5x5 window generator; window registered 1 cycle after its completing pixel.
// No backpressure: one pixel accepted per in_valid cycle, one window emitted per qualifying pixel.
module window_gen_5x5 #(
  parameter int DATA_WIDTH = window_gen_5x5_pkg::DATA_WIDTH,
  parameter int IMG_W      = window_gen_5x5_pkg::IMG_W_DEF,
  parameter int IMG_H      = window_gen_5x5_pkg::IMG_H_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [DATA_WIDTH-1:0]    in_pixel,
  output logic                     out_valid,
  output logic [25*DATA_WIDTH-1:0] out_win_25P,
  output logic                     out_eof
);
  import window_gen_5x5_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL - 1);

  logic [CW-1:0] col_cnt, cur_col;
  logic [RW-1:0] row_cnt, cur_row;
  logic          emit, last;

  // tap[r] is the pixel of row (cur_row-4+r) in the current column.
  logic [DATA_WIDTH-1:0] tap     [KERNEL];
  logic [DATA_WIDTH-1:0] win     [KERNEL][KERNEL];
  logic [DATA_WIDTH-1:0] win_nxt [KERNEL][KERNEL];

  assign tap[KERNEL-1] = in_pixel;

  for (genvar i = 0; i < KERNEL - 1; i++) begin : g_line
    line_delay #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_W)
    ) u_line_delay (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (in_valid),
      .din  (tap[i+1]),
      .dout (tap[i])
    );
  end

  // sof forces the current pixel to (0,0) regardless of the counters.
  assign cur_col = in_sof ? '0 : col_cnt;
  assign cur_row = in_sof ? '0 : row_cnt;
  assign emit    = in_valid && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
  assign last    = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  always_comb begin
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
      win_nxt[r][KERNEL-1] = tap[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_cnt <= cur_col + 1'b1;
        row_cnt <= cur_row;
      end
    end
  end

  // Window contents are only emitted once fully refilled, so no reset needed.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      win <= win_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_eof     <= 1'b0;
      out_win_25P <= '0;
    end else begin
      out_valid <= emit;
      out_eof   <= emit && last;
      if (emit) begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL; c++) begin
            out_win_25P[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] <= win_nxt[r][c];
          end
        end
      end
    end
  end
endmodule

// File: doc/window_gen_5x5.md
WINDOW_GEN_5X5 -- requirements
Module: window_gen_5x5

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the pixel width in bits, two's-complement fixed-point, passed through unmodified.
REQ-002 Parameter IMG_W, default 28, is the input image width in pixels (legal range 5..1024).
REQ-003 Parameter IMG_H, default 28, is the input image height in pixels (legal range 5..1024).
REQ-004 Port clk, input, 1, is the single clock; all state is updated on its rising edge.
REQ-005 Port rst_n, input, 1, is the asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1, qualifies in_pixel and in_sof for the current cycle.
REQ-007 Port in_sof, input, 1, marks the current valid pixel as image position (row 0, col 0).
REQ-008 Port in_pixel, input, DATA_WIDTH, carries one raster-order pixel (row-major, left to right).
REQ-009 Port out_valid, output, 1, qualifies out_win_25P for exactly one cycle per window.
REQ-010 Port out_win_25P, output, 25*DATA_WIDTH, carries one 5x5 window; element k = r*5+c occupies bits [k*DATA_WIDTH +: DATA_WIDTH], where r = 0 is the top (oldest) row and c = 0 the left (oldest) column.
REQ-011 Port out_eof, output, 1, is high together with out_valid on the last window of a frame.

Function
REQ-012 The block has no backpressure; downstream compute is fully pipelined and accepts one window per cycle.
REQ-013 Input pixels are accepted only in cycles where in_valid = 1; cycles with in_valid = 0 change no state except clearing out_valid and out_eof.
REQ-014 The block keeps a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) that name the position of the current accepted pixel.
REQ-015 A valid pixel with in_sof = 1 is position (0,0) regardless of counter state, which means a frame in progress is abandoned.
REQ-016 After the pixel at (row, col) is accepted, the counters advance: col wraps from IMG_W-1 to 0 and increments row, and row wraps from IMG_H-1 to 0 to start an implicit next frame.
REQ-017 Four line delays of depth IMG_W and a 5x5 register window hold the last five rows; the window shifts left by one column per accepted pixel.
REQ-018 A window is emitted for the accepted pixel at (row, col) if and only if row >= 4 and col >= 4.
REQ-019 The emitted window for pixel (row, col) has element (r, c) equal to the image pixel (row-4+r, col-4+c).
REQ-020 Latency: out_valid and out_win_25P are registered and appear in the cycle after the completing pixel's acceptance edge, so the latency is 1 cycle.
REQ-021 out_win_25P holds its last value while out_valid = 0.
REQ-022 out_eof = 1 only on the window of pixel (IMG_H-1, IMG_W-1).
REQ-023 Each frame yields exactly (IMG_H-4)*(IMG_W-4) windows, which is 576 with the defaults.
REQ-024 Line-delay contents are not cleared at reset or sof; REQ-018 guarantees that stale data is never emitted.

Reset
REQ-025 While rst_n = 0: out_valid = 0, out_eof = 0, out_win_25P = 0, and both counters = 0.
REQ-026 Reset asserted mid-frame aborts the frame; the first valid pixel after release is position (0,0) even if in_sof = 0.

Structure
REQ-027 The shared package holds DATA_WIDTH, the kernel size constant KERNEL = 5, and the default IMG_W/IMG_H constants.
REQ-028 A single sub-module, line_delay, implements the IMG_W-deep, valid-enabled delay line and is instantiated four times.

Verification
REQ-029 Ramp frame: 28x28 image with pixel = row*28+col, in_sof on the first pixel, and continuous in_valid.
- out_valid first rises the cycle after pixel 116.
- That window has element 0 = 0, element 12 = 58, and element 24 = 116.
- Exactly 576 windows are emitted, and out_eof = 1 only on the last, whose element 24 = 783.
REQ-030 Same ramp frame with in_valid randomly low for 50% of cycles: the window sequence and values are identical to REQ-029, and out_win_25P is stable during gaps.
REQ-031 Back-to-back frames with no in_sof on the second frame: the second frame yields 576 windows, its first window element 0 = 0, and it has no spurious windows at the frame seam.
REQ-032 in_sof reasserted at pixel (10,3) mid-frame: the counters restart, no window appears until the new row 4 col 4, and the new frame produces 576 windows.
REQ-033 rst_n pulsed low at pixel (15,15): all outputs are 0 immediately (asynchronously), and the ramp restarted without in_sof produces the REQ-029 results.
REQ-034 IMG_W=5, IMG_H=5: exactly one window per frame, equal to the full image, with out_valid and out_eof both high.
